// File: rtl/vend_coin_scheduler_if.sv
// rtl/vend_coin_scheduler_if.sv - coin/bill intake, credit and actuator signals of the coin scheduler
interface vend_coin_scheduler_if;
   logic       coin_valid;
   logic [1:0] coin_value;
   logic       coin_ready;
   logic       bill_valid;
   logic       bill_ready;
   logic [1:0] money;
   logic       dispense;
   logic       change;
   logic       motor_on;
   logic       hopper_on;
   logic       busy;

   modport master (
      output coin_valid, coin_value, bill_valid, dispense, change,
      input  coin_ready, bill_ready, money, motor_on, hopper_on, busy
   );

   modport slave (
      input  coin_valid, coin_value, bill_valid, dispense, change,
      output coin_ready, bill_ready, money, motor_on, hopper_on, busy
   );
endinterface

// File: rtl/vend_coin_scheduler.sv
// rtl/vend_coin_scheduler.sv - buffers coins and bills, issues credits round-robin with a gap,
// and sequences the dispense motor and change hopper from the vending FSM flags
module vend_coin_scheduler #(
   parameter int DEPTH    = 4,
   parameter int DISP_CYC = 8,
   parameter int CHG_CYC  = 4
) (
   input logic                 clk,
   input logic                 rst,
   vend_coin_scheduler_if.slave bus
);
   localparam int PW   = $clog2(DEPTH);
   localparam int MAXC = (DISP_CYC > CHG_CYC) ? DISP_CYC : CHG_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_VEND   = 3'd3;
   localparam logic [2:0] S_REFUND = 3'd4;

   logic [1:0]    r_coin_mem [DEPTH];
   logic [PW-1:0] r_coin_wp;
   logic [PW-1:0] r_coin_rp;
   logic [PW:0]   r_coin_cnt;
   logic [PW:0]   r_bill_cnt;
   logic [2:0]    r_state;
   logic [1:0]    r_money;
   logic [CW-1:0] r_dur;
   logic          r_last_bill;

   logic w_coin_rdy;
   logic w_bill_rdy;
   logic w_coin_ne;
   logic w_bill_ne;
   logic w_coin_push;
   logic w_bill_push;
   logic w_idle;
   logic w_grant_coin;
   logic w_pop_any;
   logic w_coin_pop;
   logic w_bill_pop;

   assign w_coin_ne    = (r_coin_cnt != '0);
   assign w_bill_ne    = (r_bill_cnt != '0);
   assign w_coin_rdy   = (r_coin_cnt != (PW+1)'(DEPTH)) & !rst;
   assign w_bill_rdy   = (r_bill_cnt <  (PW+1)'(DEPTH)) & !rst;
   // An invalid coin completes the handshake but never occupies a slot.
   assign w_coin_push  = bus.coin_valid & w_coin_rdy & (bus.coin_value != 2'b00);
   assign w_bill_push  = bus.bill_valid & w_bill_rdy;
   assign w_idle       = (r_state == S_IDLE);
   assign w_grant_coin = w_coin_ne & (!w_bill_ne | r_last_bill);
   assign w_pop_any    = w_idle & (w_coin_ne | w_bill_ne);
   assign w_coin_pop   = w_pop_any & w_grant_coin;
   assign w_bill_pop   = w_pop_any & !w_grant_coin;

   always_ff @(posedge clk) begin
      if (w_coin_push) begin
         r_coin_mem[r_coin_wp] <= bus.coin_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_coin_wp  <= '0;
         r_coin_rp  <= '0;
         r_coin_cnt <= '0;
         r_bill_cnt <= '0;
      end else begin
         if (w_coin_push) r_coin_wp <= r_coin_wp + 1'b1;
         if (w_coin_pop)  r_coin_rp <= r_coin_rp + 1'b1;
         r_coin_cnt <= r_coin_cnt + (PW+1)'(w_coin_push) - (PW+1)'(w_coin_pop);
         r_bill_cnt <= r_bill_cnt + (PW+1)'(w_bill_push) - (PW+1)'(w_bill_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_money     <= 2'b00;
         r_dur       <= '0;
         r_last_bill <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop_any) begin
                  r_money     <= w_grant_coin ? r_coin_mem[r_coin_rp] : 2'b11;
                  r_last_bill <= !w_grant_coin;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_money <= 2'b00;
               r_state <= S_GAP;
            end
            // The FSM has reacted to the credit by now; dispense outranks change.
            S_GAP: begin
               if (bus.dispense) begin
                  r_dur   <= CW'(DISP_CYC - 1);
                  r_state <= S_VEND;
               end else if (bus.change) begin
                  r_dur   <= CW'(CHG_CYC - 1);
                  r_state <= S_REFUND;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_VEND, S_REFUND: begin
               if (r_dur == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_dur <= r_dur - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_money <= 2'b00;
            end
         endcase
      end
   end

   assign bus.coin_ready = w_coin_rdy;
   assign bus.bill_ready = w_bill_rdy;
   assign bus.money      = r_money;
   assign bus.motor_on   = (r_state == S_VEND);
   assign bus.hopper_on  = (r_state == S_REFUND);
   assign bus.busy       = !w_idle | w_coin_ne | w_bill_ne;
endmodule

// File: tb/tb_vend_coin_scheduler.sv
// tb/tb_vend_coin_scheduler.sv - scoreboard bench for vend_coin_scheduler with a vending FSM model
module tb_vend_coin_scheduler;
   logic clk;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   int   exp_q[$];
   int   exp_motor[$];
   int   exp_hopper[$];
   int   money_cyc[$];
   int   motor_rise_cyc = -1;
   int   n_motor_runs = 0;
   int   n_credit = 0;
   int   disp_at = -1;
   int   chg_at = -1;

   vend_coin_scheduler_if bus();

   vend_coin_scheduler #(.DEPTH(4), .DISP_CYC(8), .CHG_CYC(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Vending FSM model: raises its flags on the edge ending ISSUE and drops them after GAP.
   initial begin
      int hold;
      hold = 0;
      bus.dispense = 1'b0;
      bus.change   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.dispense = 1'b0;
            bus.change   = 1'b0;
            hold = 0;
         end else if (bus.money != 2'b00) begin
            n_credit++;
            if (n_credit == disp_at) bus.dispense = 1'b1;
            if (n_credit == chg_at)  bus.change   = 1'b1;
            hold = 2;
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               bus.dispense = 1'b0;
               bus.change   = 1'b0;
            end
         end
      end
   end

   // Monitor: scoreboard for credits and actuator run lengths.
   initial begin
      int  motor_run;
      int  hopper_run;
      logic prev_nz;
      motor_run = 0;
      hopper_run = 0;
      prev_nz = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.money != 2'b00) begin
            money_cyc.push_back(cyc);
            check("money_one_cycle", int'(prev_nz), 0);
            if (exp_q.size() == 0) check("unexpected_money", int'(bus.money), 0);
            else                   check("money_value", int'(bus.money), exp_q.pop_front());
         end
         prev_nz = (bus.money != 2'b00);
         if (bus.motor_on || bus.hopper_on)
            check("motor_hopper_excl", int'(bus.motor_on & bus.hopper_on), 0);
         if (bus.motor_on) begin
            motor_run++;
            if (motor_run == 1) begin
               motor_rise_cyc = cyc;
               n_motor_runs++;
            end
         end else if (motor_run > 0) begin
            if (exp_motor.size() == 0) check("unexpected_motor_run", motor_run, 0);
            else                       check("motor_len", motor_run, exp_motor.pop_front());
            motor_run = 0;
         end
         if (bus.hopper_on) begin
            hopper_run++;
         end else if (hopper_run > 0) begin
            if (exp_hopper.size() == 0) check("unexpected_hopper_run", hopper_run, 0);
            else                        check("hopper_len", hopper_run, exp_hopper.pop_front());
            hopper_run = 0;
         end
      end
   end

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic push_coin(input logic [1:0] v, output int acc_cyc);
      int n;
      n = 0;
      bus.coin_valid = 1'b1;
      bus.coin_value = v;
      while (bus.coin_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("coin_push_timeout", 0, 1);
      @(negedge clk);
      bus.coin_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic push_bill(output int acc_cyc);
      int n;
      n = 0;
      bus.bill_valid = 1'b1;
      while (bus.bill_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("bill_push_timeout", 0, 1);
      @(negedge clk);
      bus.bill_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((bus.busy || bus.motor_on || bus.hopper_on) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check({name, "_idle_timeout"}, 0, 1);
   endtask

   initial begin
      int e;
      int idx0;
      int runs0;
      int n;
      rst = 1'b1;
      bus.coin_valid = 1'b0;
      bus.coin_value = 2'b00;
      bus.bill_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_coin_ready", int'(bus.coin_ready), 0);
      check("rst_bill_ready", int'(bus.bill_ready), 0);
      check("rst_money", int'(bus.money), 0);
      check("rst_motor", int'(bus.motor_on), 0);
      check("rst_hopper", int'(bus.hopper_on), 0);
      check("rst_busy", int'(bus.busy), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_coin_ready", int'(bus.coin_ready), 1);
      check("post_rst_bill_ready", int'(bus.bill_ready), 1);

      // Single coin: credit in the 2nd cycle after the push, busy clears 2 cycles later
      exp_q.push_back(2);
      push_coin(2'b10, e);
      check("single_idle_money", int'(bus.money), 0);
      check("single_idle_busy", int'(bus.busy), 1);
      @(negedge clk);
      check("single_issue_money", int'(bus.money), 2);
      check("single_issue_cycle", cyc, e + 1);
      @(negedge clk);
      check("single_gap_money", int'(bus.money), 0);
      check("single_gap_busy", int'(bus.busy), 1);
      @(negedge clk);
      check("single_busy_fall", int'(bus.busy), 0);

      // Vend on the third credit
      disp_at = n_credit + 3;
      idx0 = money_cyc.size();
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
      exp_motor.push_back(8);
      push_coin(2'b01, e);
      push_coin(2'b01, e);
      push_coin(2'b10, e);
      wait_idle("vend");
      @(negedge clk);
      check("vend_pulse_count", money_cyc.size() - idx0, 3);
      if (money_cyc.size() - idx0 >= 3) begin
         check("vend_spacing_1", money_cyc[idx0+1] - money_cyc[idx0], 3);
         check("vend_spacing_2", money_cyc[idx0+2] - money_cyc[idx0+1], 3);
         check("vend_motor_start", motor_rise_cyc, money_cyc[idx0+2] + 2);
      end

      // Refund after a coin then a bill
      chg_at = n_credit + 2;
      runs0 = n_motor_runs;
      exp_q.push_back(1); exp_q.push_back(3);
      exp_hopper.push_back(4);
      push_coin(2'b01, e);
      push_bill(e);
      wait_idle("refund");
      @(negedge clk);
      check("refund_no_motor", n_motor_runs - runs0, 0);

      // Round-robin and full: a bill credit triggers a vend that blocks issue while both fill
      disp_at = n_credit + 1;
      exp_q.push_back(3);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(1);
         exp_q.push_back(3);
      end
      exp_motor.push_back(8);
      push_bill(e);
      bus.coin_valid = 1'b1;
      bus.coin_value = 2'b01;
      bus.bill_valid = 1'b1;
      n = 0;
      while ((bus.coin_ready || bus.bill_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rr_both_full", int'(bus.coin_ready | bus.bill_ready), 0);
      check("rr_still_vending", int'(bus.motor_on), 1);
      bus.coin_valid = 1'b0;
      bus.bill_valid = 1'b0;
      wait_idle("rr");
      check("rr_drained", exp_q.size(), 0);

      // Invalid coin is consumed without a credit
      @(negedge clk);
      push_coin(2'b00, e);
      check("invalid_coin_busy", int'(bus.busy), 0);
      repeat (3) @(negedge clk);
      check("invalid_coin_no_money", int'(bus.money), 0);

      // Reset in the 3rd VEND cycle with a coin and a bill queued
      disp_at = n_credit + 1;
      exp_q.push_back(2);
      exp_motor.push_back(3);
      push_coin(2'b10, e);
      push_coin(2'b01, e);
      push_bill(e);
      n = 0;
      while (!bus.motor_on && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rstv_motor_started", int'(bus.motor_on), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstv_motor", int'(bus.motor_on), 0);
      check("rstv_money", int'(bus.money), 0);
      check("rstv_busy", int'(bus.busy), 0);
      check("rstv_coin_ready", int'(bus.coin_ready), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("rstv_stays_idle", int'(bus.busy), 0);

      check("end_exp_money_empty", exp_q.size(), 0);
      check("end_exp_motor_empty", exp_motor.size(), 0);
      check("end_exp_hopper_empty", exp_hopper.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
